// File: rtl/uk101_text_pkg.sv
// uk101_text_pkg: state encoding and ASCII constants shared by the text load sequencer.
package uk101_text_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_FETCH,
        S_PRESENT,
        S_GAP,
        S_DONE
    } tl_state_t;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_NUL = 8'h00;
    localparam logic [7:0] ASCII_EOF = 8'h1A;

endpackage

// File: rtl/text_buffer_ram.sv
// text_buffer_ram: simple dual-port 2**ADDR_W x 8 RAM, one write port and one registered read port.
module text_buffer_ram #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [2**ADDR_W];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/text_load_sequencer.sv
// text_load_sequencer: captures an ioctl text download and replays it, paced, to a character sink.
// Define UK101_LF_STRIP_EN to skip 0x0A bytes during playback so CRLF files play as CR-only.
module text_load_sequencer
    import uk101_text_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int CHAR_GAP = 50000,
    parameter int LINE_GAP = 5000000,
    parameter int GAP_W    = 23
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    input  logic              abort,
    output logic              char_valid,
    output logic [7:0]        char_data,
    input  logic              char_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   load_len
);

    localparam int LW = ADDR_W + 1;

    tl_state_t         state_q, state_d;
    logic [LW-1:0]     index_q, index_d;
    logic [LW-1:0]     len_q, len_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [7:0]        data_q, data_d;
    logic              pend_q, pend_d;
    logic              ram_we, ram_re;
    logic [7:0]        ram_rdata;
    logic [LW-1:0]     wr_len;
    logic              playing;

    text_buffer_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk    (clk),
        .wr_en  (ram_we),
        .wr_addr(dl_addr),
        .wr_data(dl_data),
        .rd_en  (ram_re),
        .rd_addr(index_q[ADDR_W-1:0]),
        .rd_data(ram_rdata)
    );

    assign wr_len  = LW'(dl_addr) + 1'b1;
    assign ram_we  = (state_q == S_CAPTURE) && dl_wr;
    assign playing = (state_q == S_FETCH) || (state_q == S_PRESENT) || (state_q == S_GAP);

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        len_d   = len_q;
        gap_d   = gap_q;
        data_d  = data_q;
        pend_d  = 1'b0;
        ram_re  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dl_active) begin
                    state_d = S_CAPTURE;
                    len_d   = '0;
                end
            end
            S_CAPTURE: begin
                if (dl_wr && wr_len > len_q) len_d = wr_len;
                if (!dl_active) begin
                    state_d = (len_d != '0) ? S_FETCH : S_IDLE;
                    index_d = '0;
                end
            end
            S_FETCH: begin
                // First cycle issues the read; the second consumes the registered RAM output.
                if (!pend_q) begin
                    if (index_q == len_q) state_d = S_DONE;
                    else begin
                        ram_re = 1'b1;
                        pend_d = 1'b1;
                    end
                end else if (ram_rdata == ASCII_NUL || ram_rdata == ASCII_EOF) begin
                    state_d = S_DONE;
`ifdef UK101_LF_STRIP_EN
                end else if (ram_rdata == ASCII_LF) begin
                    index_d = index_q + 1'b1;
`endif
                end else begin
                    data_d  = ram_rdata;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (char_ready) begin
                    state_d = S_GAP;
                    gap_d   = (data_q == ASCII_CR) ? GAP_W'(LINE_GAP) : GAP_W'(CHAR_GAP);
                end
            end
            S_GAP: begin
                // Leaving on the last counted cycle keeps rise-to-rise spacing at gap+3.
                gap_d = gap_q - 1'b1;
                if (gap_q <= GAP_W'(1)) begin
                    state_d = S_FETCH;
                    index_d = index_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (playing && abort) state_d = S_IDLE;
        if ((playing || state_q == S_DONE) && dl_active) begin
            state_d = S_CAPTURE;
            len_d   = '0;
        end
        if (state_d != S_FETCH) pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            index_q <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
        end
    end

    assign char_valid = (state_q == S_PRESENT);
    assign char_data  = data_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign load_len   = len_q;

endmodule

// File: tb/tb_text_load_sequencer.sv
// tb_text_load_sequencer: randomized scenario bench for text_load_sequencer against a byte-stream model.
module tb_text_load_sequencer;

    localparam int AW = 13;
    localparam int CG = 4;
    localparam int LG = 20;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic          dl_active = 1'b0;
    logic          dl_wr = 1'b0;
    logic [AW-1:0] dl_addr = '0;
    logic [7:0]    dl_data = '0;
    logic          abort = 1'b0;
    logic          char_valid;
    logic [7:0]    char_data;
    logic          char_ready = 1'b0;
    logic          busy;
    logic          done;
    logic [AW:0]   load_len;

    int tests = 0;
    int fails = 0;

    int  cyc = 0;
    bq_t got;
    int  rises[$];
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  last_hs = 0;
    logic pv = 1'b0;

    text_load_sequencer #(.ADDR_W(AW), .CHAR_GAP(CG), .LINE_GAP(LG), .GAP_W(23)) dut (
        .clk(clk), .n_reset(n_reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .abort(abort),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
        .busy(busy), .done(done), .load_len(load_len)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (char_valid && char_ready) begin
            got.push_back(char_data);
            last_hs = cyc;
        end
        if (char_valid && !pv) rises.push_back(cyc);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        pv = char_valid;
    end

    // Expected transfers: stop at NUL/EOF, optionally drop LF, everything else in order.
    function automatic bq_t model(bq_t b);
        bq_t e;
        for (int i = 0; i < b.size(); i++) begin
            if (b[i] == 8'h00 || b[i] == 8'h1A) break;
`ifdef UK101_LF_STRIP_EN
            if (b[i] == 8'h0A) continue;
`endif
            e.push_back(b[i]);
        end
        return e;
    endfunction

    function automatic bit same(bq_t a, bq_t b);
        if (a.size() != b.size()) return 1'b0;
        for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got.delete();
        rises.delete();
        done_cnt = 0;
    endtask

    task automatic download(input bq_t b, input bit rev, input bit already);
        if (!already) begin
            dl_active = 1'b1;
            step();
        end
        for (int k = 0; k < b.size(); k++) begin
            int a;
            a = rev ? b.size() - 1 - k : k;
            dl_wr = 1'b1;
            dl_addr = AW'(a);
            dl_data = b[a];
            step();
            dl_wr = 1'b0;
            if ($urandom_range(0, 2) == 0) step();
        end
        dl_active = 1'b0;
        step();
    endtask

    task automatic play(input string name, input bit rnd);
        for (int k = 0; k < 6000; k++) begin
            char_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            if (done) break;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s_timeout: done=%b, required 1 within 6000 cycles", name, done);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        tests++;
        if ({char_valid, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: valid/busy/done=%b, required 000", {char_valid, busy, done});
        end
        tests++;
        if (load_len !== '0 || char_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_values: load_len=%0d char_data=%h, required 0 and 00", load_len, char_data);
        end
        #3 n_reset = 1'b1;
        step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        bq_t b, e;
        b = {8'h31, 8'h30, 8'h20, 8'h50, 8'h52, 8'h49, 8'h4E, 8'h54, 8'h20, 8'h31, 8'h0D};
        clear_mon();
        download(b, 1'b0, 1'b0);
        tests++;
        if (load_len !== 14'd11) begin
            fails++;
            $display("FAIL basic_len: load_len=%0d, required 11", load_len);
        end
        play("basic", 1'b0);
        step();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL basic_after_done: busy=%b done=%b, required 0 0", busy, done);
        end
        repeat (5) step();
        e = model(b);
        tests++;
        if (!same(got, e)) begin
            fails++;
            $display("FAIL basic_stream: got %p, required %p", got, e);
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL basic_done_count: %0d pulses, required 1", done_cnt);
        end
        for (int i = 0; i + 1 < rises.size(); i++) begin
            tests++;
            if (rises[i+1] - rises[i] != ((b[i] == 8'h0D) ? LG : CG) + 3) begin
                fails++;
                $display("FAIL basic_spacing[%0d]: %0d clocks, required %0d", i, rises[i+1] - rises[i], CG + 3);
            end
        end
        tests++;
        if (done_cyc - last_hs < LG) begin
            fails++;
            $display("FAIL basic_line_gap: %0d clocks CR to done, required at least %0d", done_cyc - last_hs, LG);
        end
    endtask

    task automatic test_backpressure();
        bq_t b, e;
        int bad;
        b = {8'h50, 8'h51};
        clear_mon();
        char_ready = 1'b0;
        download(b, 1'b0, 1'b0);
        for (int k = 0; k < 20 && !char_valid; k++) step();
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (char_valid !== 1'b1 || char_data !== 8'h50) bad++;
            step();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_stable: %0d of 50 stalled cycles unstable (valid=%b data=%h), required 0", bad, char_valid, char_data);
        end
        tests++;
        if (got.size() != 0) begin
            fails++;
            $display("FAIL bp_no_transfer: %0d transfers while stalled, required 0", got.size());
        end
        char_ready = 1'b1;
        step();
        char_ready = 1'b0;
        repeat (3) step();
        tests++;
        if (got.size() != 1) begin
            fails++;
            $display("FAIL bp_single: %0d transfers after one ready cycle, required 1", got.size());
        end
        play("bp", 1'b0);
        repeat (3) step();
        e = model(b);
        tests++;
        if (!same(got, e)) begin
            fails++;
            $display("FAIL bp_stream: got %p, required %p", got, e);
        end
    endtask

    task automatic test_terminator();
        bq_t b, e;
        b = {8'h41, 8'h42, 8'h1A, 8'h43};
        clear_mon();
        download(b, 1'b1, 1'b0);
        play("term", 1'b1);
        repeat (10) step();
        e = model(b);
        tests++;
        if (!same(got, e) || e.size() != 2) begin
            fails++;
            $display("FAIL term_stream: got %p, required 41 42 only", got);
        end
        tests++;
        if (done_cnt != 1 || rises.size() != 2) begin
            fails++;
            $display("FAIL term_counts: done=%0d presents=%0d, required 1 and 2", done_cnt, rises.size());
        end
    endtask

    task automatic test_redownload();
        bq_t b1, b2;
        for (int i = 0; i < 10; i++) b1.push_back(8'($urandom_range(32, 126)));
        for (int i = 0; i < 5; i++) b2.push_back(8'($urandom_range(32, 126)));
        clear_mon();
        download(b1, 1'b0, 1'b0);
        char_ready = 1'b1;
        for (int k = 0; k < 500 && got.size() < 3; k++) step();
        tests++;
        if (got.size() != 3 || char_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL redl_gap: transfers=%0d valid=%b busy=%b, required 3 0 1", got.size(), char_valid, busy);
        end
        dl_active = 1'b1;
        step();
        tests++;
        if (char_valid !== 1'b0 || busy !== 1'b1 || load_len !== '0) begin
            fails++;
            $display("FAIL redl_capture: valid=%b busy=%b load_len=%0d, required 0 1 0", char_valid, busy, load_len);
        end
        got.delete();
        download(b2, 1'b0, 1'b1);
        tests++;
        if (load_len !== 14'd5) begin
            fails++;
            $display("FAIL redl_len: load_len=%0d, required 5", load_len);
        end
        play("redl", 1'b0);
        repeat (3) step();
        tests++;
        if (!same(got, b2)) begin
            fails++;
            $display("FAIL redl_stream: got %p, required %p", got, b2);
        end
    endtask

    task automatic test_abort();
        bq_t b;
        int r;
        for (int i = 0; i < 6; i++) b.push_back(8'($urandom_range(32, 126)));
        clear_mon();
        char_ready = 1'b0;
        download(b, 1'b0, 1'b0);
        for (int k = 0; k < 20 && !char_valid; k++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++;
        if (char_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_stop: valid=%b busy=%b, required 0 0", char_valid, busy);
        end
        char_ready = 1'b1;
        repeat (20) step();
        tests++;
        if (done_cnt != 0 || got.size() != 0) begin
            fails++;
            $display("FAIL abort_quiet: done=%0d transfers=%0d, required 0 0", done_cnt, got.size());
        end
        r = rises.size();
        dl_active = 1'b1;
        step();
        dl_active = 1'b0;
        step();
        step();
        tests++;
        if (busy !== 1'b0 || load_len !== '0) begin
            fails++;
            $display("FAIL empty_dl: busy=%b load_len=%0d, required 0 0", busy, load_len);
        end
        repeat (20) step();
        tests++;
        if (rises.size() != r || done_cnt != 0) begin
            fails++;
            $display("FAIL empty_quiet: presents=%0d done=%0d, required %0d 0", rises.size(), done_cnt, r);
        end
    endtask

    task automatic test_lf();
        bq_t b, e;
        b = {8'h41, 8'h0D, 8'h0A, 8'h42};
        clear_mon();
        download(b, 1'b0, 1'b0);
        play("lf", 1'b1);
        repeat (3) step();
        e = model(b);
        tests++;
        if (!same(got, e)) begin
            fails++;
            $display("FAIL lf_stream: got %p, required %p", got, e);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            bq_t b, e;
            int n;
            n = $urandom_range(1, 30);
            for (int i = 0; i < n; i++) begin
                int r;
                r = $urandom_range(0, 99);
                b.push_back(r < 5 ? 8'h0D : r < 10 ? 8'h0A : r < 12 ? 8'h1A : r < 13 ? 8'h00 : 8'($urandom_range(32, 126)));
            end
            clear_mon();
            download(b, 1'($urandom_range(0, 1)), 1'b0);
            tests++;
            if (load_len !== 14'(n)) begin
                fails++;
                $display("FAIL rand%0d_len: load_len=%0d, required %0d", it, load_len, n);
            end
            play("rand", 1'b1);
            repeat (3) step();
            e = model(b);
            tests++;
            if (!same(got, e) || done_cnt != 1) begin
                fails++;
                $display("FAIL rand%0d_stream: got %p done=%0d, required %p done=1", it, got, done_cnt, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_terminator();
        test_redownload();
        test_abort();
        test_lf();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
